muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit downstream of the RegisterFile read ports.
- Consumes rs1/rs2 values (dataA/dataB), computes the M-extension result over multiple cycles, and presents a one-cycle writeback (rd, result, wb_en) that feeds the RegisterFile write port (addrD/dataD/reg_write).
- Core control stalls on busy.

---
 rtl/muldiv_unit_if.sv | 41 ++++
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if
// Request/writeback bundle between the core and the iterative RV32M
// multiply/divide unit.
//   start   : request strobe, only taken while the unit is not busy
//   funct3  : M-extension operation select
//   op_a    : rs1 value (RegisterFile dataA)
//   op_b    : rs2 value (RegisterFile dataB)
//   rd_in   : destination register of the request
//   busy    : operation in progress, core stalls on it
//   done    : one-cycle completion pulse
//   wb_en   : done qualified by rd_out != x0 (RegisterFile reg_write)
//   rd_out  : destination register of the completed operation
//   result  : completed result, held until the next completion
// master = core side (drives the request), slave = muldiv_unit.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              start;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [REG_AW-1:0] rd_in;
    logic              busy;
    logic              done;
    logic              wb_en;
    logic [REG_AW-1:0] rd_out;
    logic [XLEN-1:0]   result;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, wb_en, rd_out, result
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, wb_en, rd_out, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit. Operands are converted to
// magnitudes on acceptance, processed one bit per cycle (shift-add multiply
// or restoring divide), then sign-corrected and selected in a single FIX
// cycle. Divide-by-zero and signed overflow complete in one cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, clears all state
//   bus   : muldiv_unit_if.slave request/writeback bundle
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_funct3;
    logic [REG_AW-1:0]   r_rd;
    logic                r_sa;
    logic                r_sb;
    logic [XLEN-1:0]     r_a_mag;
    logic [XLEN-1:0]     r_b_mag;
    logic [2*XLEN-1:0]   r_acc;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_wb_en;
    logic [REG_AW-1:0]   r_rd_out;
    logic [XLEN-1:0]     r_result;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_a_mag;
    logic [XLEN-1:0]     w_b_mag;
    logic                w_div_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_accept;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_sh;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_result;

    // Two's complement negation of an XLEN-bit word.
    function automatic logic [XLEN-1:0] f_neg(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Two's complement negation of the double-width product.
    function automatic logic [2*XLEN-1:0] f_neg2(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    // Request decode: operand signedness, magnitudes and one-cycle special cases.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (bus.funct3)
            3'b001:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:  begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            3'b100:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b110:  begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default: begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_sa    = w_a_signed & bus.op_a[XLEN-1];
        w_sb    = w_b_signed & bus.op_b[XLEN-1];
        w_a_mag = w_sa ? f_neg(bus.op_a) : bus.op_a;
        w_b_mag = w_sb ? f_neg(bus.op_b) : bus.op_b;

        w_div_zero = bus.funct3[2] && (bus.op_b == {XLEN{1'b0}});
        // Signed most-negative / -1 (DIV and REM only).
        w_ovf = bus.funct3[2] && !bus.funct3[0]
              && (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
              && (bus.op_b == {XLEN{1'b1}});
        w_special = w_div_zero | w_ovf;

        // funct3[1] separates REM/REMU from DIV/DIVU.
        if (w_div_zero) begin
            w_special_res = bus.funct3[1] ? bus.op_a : {XLEN{1'b1}};
        end else begin
            w_special_res = bus.funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
        end

        w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    end

    // One iteration of shift-add multiply and restoring divide on r_acc.
    always_comb begin
        // Multiply: low half holds the remaining multiplier bits, high half the partial product.
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]}
                   + (r_acc[0] ? {1'b0, r_a_mag} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
        w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
        w_div_diff = w_div_sh - {1'b0, r_b_mag};
        if (w_div_diff[XLEN]) begin
            w_div_next = {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? f_neg2(r_acc) : r_acc;
        w_quo  = (r_sa ^ r_sb) ? f_neg(r_acc[XLEN-1:0]) : r_acc[XLEN-1:0];
        w_rem  = r_sa ? f_neg(r_acc[2*XLEN-1:XLEN]) : r_acc[2*XLEN-1:XLEN];
        case (r_funct3)
            3'b000:  w_fix_result = w_prod[XLEN-1:0];
            3'b001:  w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b010:  w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b011:  w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100:  w_fix_result = w_quo;
            3'b101:  w_fix_result = w_quo;
            3'b110:  w_fix_result = w_rem;
            3'b111:  w_fix_result = w_rem;
            default: w_fix_result = {XLEN{1'b0}};
        endcase
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'b000;
            r_rd     <= {REG_AW{1'b0}};
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_a_mag  <= {XLEN{1'b0}};
            r_b_mag  <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wb_en  <= 1'b0;
            r_rd_out <= {REG_AW{1'b0}};
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done  <= 1'b0;
                    r_wb_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (w_accept) begin
                        r_funct3 <= bus.funct3;
                        r_rd     <= bus.rd_in;
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_a_mag  <= w_a_mag;
                        r_b_mag  <= w_b_mag;
                        r_acc    <= {{XLEN{1'b0}}, (bus.funct3[2] ? w_a_mag : w_b_mag)};
                        r_cnt    <= {CW{1'b0}};
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_result <= w_special_res;
                            r_rd_out <= bus.rd_in;
                            r_done   <= 1'b1;
                            r_wb_en  <= (bus.rd_in != {REG_AW{1'b0}});
                        end else begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_result;
                    r_rd_out <= r_rd;
                    r_done   <= 1'b1;
                    r_wb_en  <= (r_rd != {REG_AW{1'b0}});
                    r_busy   <= 1'b0;
                    r_state  <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_wb_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.wb_en  = r_wb_en;
    assign bus.rd_out = r_rd_out;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Directed plus randomized checks of muldiv_unit against a behavioural
// model built on 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    muldiv_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

    muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference RV32M semantics from plain integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint    sa;
        longint    sb;
        logic [63:0] p;
        int        ia;
        int        ib;
        logic      ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return ia % ib;
            end
            3'd7: begin
                if (b == 32'd0) return a;
                return a % b;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1'b1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one op at the current negedge and check its completion.
    // poke: pulse start with other operands mid-operation.
    // chain: return in the DONE cycle so the caller can issue back-to-back.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input bit poke, input bit chain);
        int lat;
        int busy_cnt;
        bit sp;
        sp = is_special(f3, a, b);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        @(negedge clk);
        lat      = 1;
        busy_cnt = 0;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom_range(0, 7));
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom_range(0, 31));
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (poke && lat == 5) begin
                bus.start  = 1'b1;
                bus.funct3 = ~f3;
                bus.op_a   = $urandom;
                bus.op_b   = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), sp ? 32'd1 : 32'd34);
        check({tag, "_busycnt"}, 32'(busy_cnt), sp ? 32'd0 : 32'd33);
        check({tag, "_result"}, bus.result, ref_model(f3, a, b));
        check({tag, "_rd_out"}, 32'(bus.rd_out), 32'(rd));
        check({tag, "_wb_en"}, 32'(bus.wb_en), 32'(rd != 5'd0));
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        if (!chain) begin
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({tag, "_wb_after"}, 32'(bus.wb_en), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          sel;
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'd0;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_wb_en",  32'(bus.wb_en),  32'd0);
        check("rst_rd_out", 32'(bus.rd_out), 32'd0);
        check("rst_result", bus.result,      32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op("mul_7x6",     3'd0, 32'd7,          32'd6,          5'd5,  1'b0, 1'b0);
        check("mul_7x6_const", bus.result, 32'h0000_002A);
        run_op("mulh",        3'd1, 32'hFFFF_FFFE, 32'd3,          5'd1,  1'b0, 1'b0);
        check("mulh_const", bus.result, 32'hFFFF_FFFF);
        run_op("mulhu",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b0, 1'b0);
        check("mulhu_const", bus.result, 32'hFFFF_FFFE);
        run_op("mulhsu",      3'd2, 32'hFFFF_FFFF, 32'd2,          5'd3,  1'b0, 1'b0);
        check("mulhsu_const", bus.result, 32'hFFFF_FFFF);
        run_op("div_neg",     3'd4, 32'hFFFF_FFF9, 32'd2,          5'd4,  1'b0, 1'b0);
        check("div_neg_const", bus.result, 32'hFFFF_FFFD);
        run_op("rem_neg",     3'd6, 32'hFFFF_FFF9, 32'd2,          5'd6,  1'b0, 1'b0);
        check("rem_neg_const", bus.result, 32'hFFFF_FFFF);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7,          5'd7,  1'b0, 1'b0);
        check("divu_const", bus.result, 32'd14);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7,          5'd8,  1'b0, 1'b0);
        check("remu_const", bus.result, 32'd2);
        run_op("divu_by0",    3'd5, 32'd5,          32'd0,          5'd9,  1'b0, 1'b0);
        check("divu_by0_const", bus.result, 32'hFFFF_FFFF);
        run_op("rem_by0",     3'd6, 32'd5,          32'd0,          5'd10, 1'b0, 1'b0);
        check("rem_by0_const", bus.result, 32'd5);
        run_op("div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0, 1'b0);
        check("div_ovf_const", bus.result, 32'h8000_0000);
        run_op("rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0, 1'b0);
        check("rem_ovf_const", bus.result, 32'd0);

        run_op("poke_mid",    3'd0, 32'd1234,       32'd5678,       5'd13, 1'b1, 1'b0);
        run_op("chain_first", 3'd5, 32'd1000,       32'd3,          5'd14, 1'b0, 1'b1);
        run_op("chain_second",3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 5'd15, 1'b0, 1'b0);
        run_op("rd_zero",     3'd0, 32'd7,          32'd6,          5'd0,  1'b0, 1'b0);

        // Reset in the middle of CALC aborts immediately.
        bus.start  = 1'b1;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'h0000_1234;
        bus.op_b   = 32'h0000_0010;
        bus.rd_in  = 5'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy",   32'(bus.busy),   32'd0);
        check("midrst_done",   32'(bus.done),   32'd0);
        check("midrst_result", bus.result,      32'd0);
        check("midrst_rd_out", 32'(bus.rd_out), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op("post_rst_mul", 3'd0, 32'd3, 32'd3, 5'd1, 1'b0, 1'b0);
        check("post_rst_const", bus.result, 32'd9);

        // Randomized ops with a bias toward boundary operands.
        for (int i = 0; i < 30; i++) begin
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                b = 32'($urandom_range(1, 15));
            end else if (sel == 2) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (sel == 3) begin
                a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            end
            run_op("rand", f3, a, b, rd, 1'b0, (i % 5) == 4);
        end
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
